// File: rtl/bht_pkg.sv
// Shared types and helpers for the bimodal BHT update path.
// Widths come from the core-level configuration.
package bht_pkg;

  localparam int unsigned CVA6_VLEN         = 64;
  localparam int unsigned CVA6_INDEX_BITS   = 9;
  localparam int unsigned BHT_OFFSET        = 1;
  localparam int unsigned BHT_ROW_ADDR_BITS = 1;

  typedef struct packed {
    logic [CVA6_VLEN-1:0]       pc;
    logic [CVA6_INDEX_BITS-1:0] index;
    logic                       taken;
  } bht_upd_entry_t;

  function automatic logic [CVA6_VLEN-1:0] row_bits(
    input logic [CVA6_VLEN-1:0] pc,
    input int unsigned          offset,
    input int unsigned          row_addr_bits
  );
    logic [CVA6_VLEN-1:0] mask;
    mask = (CVA6_VLEN'(1) << row_addr_bits)
         - CVA6_VLEN'(1);
    return (pc >> offset) & mask;
  endfunction

endpackage

// File: rtl/bht_update_queue.sv
// Circular queue between branch resolution and the BHT update port.
// Optional RAW stall on back-to-back same-row updates: BHT_UPD_RAW_STALL_EN.
module bht_update_queue
  import bht_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned VLEN       = CVA6_VLEN,
  parameter int unsigned INDEX_BITS = CVA6_INDEX_BITS
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_bp_i,
  input  logic                     debug_mode_i,
  input  logic                     res_valid_i,
  input  logic [VLEN-1:0]          res_pc_i,
  input  logic [INDEX_BITS-1:0]    res_index_i,
  input  logic                     res_taken_i,
  input  logic                     upd_ready_i,
  output logic                     upd_valid_o,
  output logic [VLEN-1:0]          upd_pc_o,
  output logic [INDEX_BITS-1:0]    upd_index_o,
  output logic                     upd_taken_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  bht_upd_entry_t mem_q [DEPTH];
  bht_upd_entry_t head;
  bht_upd_entry_t wr_ent;

  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic          ovf_q;

  logic nonempty;
  logic full;
  logic push;
  logic pop;
  logic vld;

  assign nonempty = cnt_q != '0;
  assign full     = cnt_q == CW'(DEPTH);
  assign head     = mem_q[rd_q];
  assign push     = res_valid_i && !debug_mode_i
                 && !flush_bp_i;
  assign pop      = vld && upd_ready_i;

  assign wr_ent.pc    = res_pc_i;
  assign wr_ent.index = res_index_i;
  assign wr_ent.taken = res_taken_i;

`ifdef BHT_UPD_RAW_STALL_EN
  logic                  last_vld_q;
  logic [INDEX_BITS-1:0] last_idx_q;
  logic [VLEN-1:0]       last_row_q;
  logic                  stall;

  assign stall = last_vld_q
              && head.index == last_idx_q
              && row_bits(head.pc, BHT_OFFSET,
                          BHT_ROW_ADDR_BITS)
                 == last_row_q;
  assign vld = nonempty && !stall;

  // remember the row written by the last pop
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_vld_q <= 1'b0;
      last_idx_q <= '0;
      last_row_q <= '0;
    end else if (flush_bp_i) begin
      last_vld_q <= 1'b0;
    end else begin
      last_vld_q <= pop;
      if (pop) begin
        last_idx_q <= head.index;
        last_row_q <= row_bits(head.pc, BHT_OFFSET,
                               BHT_ROW_ADDR_BITS);
      end
    end
  end
`else
  assign vld = nonempty;
`endif

  // pointers, occupancy and overflow pulse
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (flush_bp_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= push && full && !pop;
      if (push)
        wr_q <= wr_q + 1'b1;
      if (pop || (push && full))
        rd_q <= rd_q + 1'b1;
      if (push && !pop && !full)
        cnt_q <= cnt_q + 1'b1;
      else if (pop && !push)
        cnt_q <= cnt_q - 1'b1;
    end
  end

  // entry storage; a full push overwrites the oldest slot
  always_ff @(posedge clk_i) begin
    if (push)
      mem_q[wr_q] <= wr_ent;
  end

  assign upd_valid_o = vld;
  assign upd_pc_o    = nonempty ? head.pc    : '0;
  assign upd_index_o = nonempty ? head.index : '0;
  assign upd_taken_o = nonempty && head.taken;
  assign count_o     = cnt_q;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_bht_update_queue.sv
// Directed bench for bht_update_queue with a scoreboard model.
// Also covers the BHT_UPD_RAW_STALL_EN build.
module tb_bht_update_queue;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_bp_i;
  logic        debug_mode_i;
  logic        res_valid_i;
  logic [63:0] res_pc_i;
  logic [8:0]  res_index_i;
  logic        res_taken_i;
  logic        upd_ready_i;
  logic        upd_valid_o;
  logic [63:0] upd_pc_o;
  logic [8:0]  upd_index_o;
  logic        upd_taken_o;
  logic [2:0]  count_o;
  logic        overflow_o;

  bht_update_queue #(
    .DEPTH(DEPTH),
    .VLEN(64),
    .INDEX_BITS(9)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .flush_bp_i(flush_bp_i),
    .debug_mode_i(debug_mode_i),
    .res_valid_i(res_valid_i),
    .res_pc_i(res_pc_i),
    .res_index_i(res_index_i),
    .res_taken_i(res_taken_i),
    .upd_ready_i(upd_ready_i),
    .upd_valid_o(upd_valid_o),
    .upd_pc_o(upd_pc_o),
    .upd_index_o(upd_index_o),
    .upd_taken_o(upd_taken_o),
    .count_o(count_o),
    .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0] pc;
    logic [8:0]  idx;
    logic        tk;
  } ent_t;

  ent_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic        exp_ovf = 1'b0;
  logic        lastv = 1'b0;
  logic [8:0]  lidx = '0;
  logic        lrow = 1'b0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // called at a negedge; checks, drives, advances one cycle
  task automatic step(input logic v,
                      input logic [63:0] pc,
                      input logic [8:0] idx,
                      input logic tk,
                      input logic rdy,
                      input logic fl,
                      input logic dbg);
    logic stall_m;
    logic exp_v;
    logic pop_m;
    logic nxt_ovf;
    ent_t e;
    stall_m = 1'b0;
`ifdef BHT_UPD_RAW_STALL_EN
    if (sb.size() != 0)
      stall_m = lastv && sb[0].idx == lidx
             && sb[0].pc[1] == lrow;
`endif
    exp_v = (sb.size() != 0) && !stall_m;
    chk("valid", 64'(upd_valid_o), 64'(exp_v));
    chk("count", 64'(count_o), 64'(sb.size()));
    chk("ovf", 64'(overflow_o), 64'(exp_ovf));
    if (sb.size() != 0) begin
      chk("pc", upd_pc_o, sb[0].pc);
      chk("idx", 64'(upd_index_o), 64'(sb[0].idx));
      chk("taken", 64'(upd_taken_o), 64'(sb[0].tk));
    end
    res_valid_i  = v;
    res_pc_i     = pc;
    res_index_i  = idx;
    res_taken_i  = tk;
    upd_ready_i  = rdy;
    flush_bp_i   = fl;
    debug_mode_i = dbg;
    pop_m   = exp_v && rdy;
    nxt_ovf = 1'b0;
    if (fl) begin
      sb.delete();
      lastv = 1'b0;
    end else begin
      lastv = pop_m;
      if (pop_m) begin
        lidx = sb[0].idx;
        lrow = sb[0].pc[1];
        void'(sb.pop_front());
      end
      if (v && !dbg) begin
        if (sb.size() == DEPTH) begin
          void'(sb.pop_front());
          nxt_ovf = 1'b1;
        end
        e.pc = pc;
        e.idx = idx;
        e.tk = tk;
        sb.push_back(e);
      end
    end
    exp_ovf = nxt_ovf;
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 64'h0, 9'h0, 1'b0, rdy, 1'b0, 1'b0);
  endtask

  initial begin
    rst_ni       = 1'b0;
    flush_bp_i   = 1'b0;
    debug_mode_i = 1'b0;
    res_valid_i  = 1'b0;
    res_pc_i     = '0;
    res_index_i  = '0;
    res_taken_i  = 1'b0;
    upd_ready_i  = 1'b0;
    #12;
    chk("rst_valid", 64'(upd_valid_o), 64'h0);
    chk("rst_count", 64'(count_o), 64'h0);
    chk("rst_ovf", 64'(overflow_o), 64'h0);
    chk("rst_pc", upd_pc_o, 64'h0);
    chk("rst_idx", 64'(upd_index_o), 64'h0);
    chk("rst_taken", 64'(upd_taken_o), 64'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // burst with ready high
    step(1, 64'h80000010, 9'd4, 1, 1, 0, 0);
    step(1, 64'h80000014, 9'd5, 0, 1, 0, 0);
    step(1, 64'h80000018, 9'd6, 1, 1, 0, 0);
    idle(1);
    idle(1);
    idle(1);

    // overflow with ready low
    for (int i = 1; i <= 5; i++)
      step(1, 64'h1000 + 64'(4 * i), 9'(i),
           1'(i), 0, 0, 0);
    idle(0);
    idle(0);

    // full push with pop
    step(1, 64'h2000, 9'd9, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++)
      idle(1);

    // flush with concurrent push
    step(1, 64'h3004, 9'd10, 0, 0, 0, 0);
    step(1, 64'h3008, 9'd11, 1, 0, 0, 0);
    step(1, 64'h300c, 9'd7, 1, 0, 1, 0);
    idle(1);
    idle(1);

    // debug mode filtering
    for (int i = 0; i < 3; i++)
      step(1, 64'h4000, 9'(20 + i), 1, 0, 0, 1);
    step(1, 64'h4010, 9'd3, 0, 0, 0, 0);
    idle(0);
    idle(1);
    idle(1);

    // back-to-back same row
    step(1, 64'h5002, 9'd12, 1, 0, 0, 0);
    step(1, 64'h5002, 9'd12, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      idle(1);

    // reset mid-operation
    step(1, 64'h6000, 9'd1, 1, 0, 0, 0);
    step(1, 64'h6004, 9'd2, 0, 0, 0, 0);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("mrst_valid", 64'(upd_valid_o), 64'h0);
    chk("mrst_count", 64'(count_o), 64'h0);
    chk("mrst_pc", upd_pc_o, 64'h0);
    sb.delete();
    exp_ovf = 1'b0;
    lastv = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    idle(1);
    idle(1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
